id_counter_dco: RTL and testbench

Increment/decrement (ID) counter and output divider for the DPLL loop. It consumes the one-cycle carry/borrow pulses produced by the K-counter loop filter (the counter's max and min triggers). From the system clock it generates a nominal f_clk/2 pulse stream, inserting one extra pulse per carry and deleting one pulse per borrow. The adjusted stream is divided by DIV_N to form the recovered clock, which feeds back to the phase detector.

---
 rtl/dpll_pkg.sv | 6 +
 rtl/pulse_divider.sv | 34 +++
 rtl/id_counter_dco.sv | 60 ++++++
 tb/tb_id_counter_dco.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
// dpll_pkg: shared types and defaults for the DPLL ID counter and divider
package dpll_pkg;
  typedef enum logic {PH_A, PH_B} phase_t;
  typedef enum logic [1:0] {PEND_NONE, PEND_ADD, PEND_DEL} pend_t;
  localparam int DIV_N_DEF = 16;
endpackage

// File: rtl/pulse_divider.sv
// pulse_divider: divides the adjusted pulse stream down to the recovered clock
module pulse_divider
  import dpll_pkg::*;
#(
  parameter int DIV_N = DIV_N_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pulse_i,
  output logic recClk_o,
  output logic wrapTick_o
);
  localparam int CNT_W = $clog2(DIV_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV_N / 2);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic wrap_d, rec_d;
  always_comb begin
    wrap_d = pulse_i && (cnt_q == LAST);
    cnt_d  = wrap_d ? '0 : cnt_q + CNT_W'(pulse_i);
    rec_d  = cnt_d >= HALF;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q      <= '0;
      recClk_o   <= 1'b0;
      wrapTick_o <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      recClk_o   <= rec_d;
      wrapTick_o <= wrap_d;
    end
  end
endmodule

// File: rtl/id_counter_dco.sv
// id_counter_dco: ID counter inserting/deleting f_clk/2 pulses on carry/borrow,
// followed by a divide-by-DIV_N producing the recovered clock
module id_counter_dco
  import dpll_pkg::*;
#(
  parameter int DIV_N = DIV_N_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic carry_i,
  input  logic borrow_i,
  output logic idPulse_o,
  output logic recClk_o,
  output logic wrapTick_o,
  output logic addDone_o,
  output logic delDone_o,
  output logic dropped_o
);
  phase_t phase_q, phase_d;
  pend_t pend_q, pend_d, pend_c;
  logic add_hit, del_hit, carry_only, borrow_only;
  logic id_d, drop_d;
  always_comb begin
    add_hit     = (phase_q == PH_A) && (pend_q == PEND_ADD);
    del_hit     = (phase_q == PH_B) && (pend_q == PEND_DEL);
    id_d        = add_hit || ((phase_q == PH_B) && !del_hit);
    phase_d     = (phase_q == PH_A) ? PH_B : PH_A;
    // new requests see the pending slot after this edge's consumption
    pend_c      = (add_hit || del_hit) ? PEND_NONE : pend_q;
    carry_only  = carry_i && !borrow_i;
    borrow_only = borrow_i && !carry_i;
    drop_d      = (carry_only && pend_c == PEND_ADD) || (borrow_only && pend_c == PEND_DEL);
    pend_d      = carry_only  ? ((pend_c == PEND_DEL) ? PEND_NONE : PEND_ADD) :
                  borrow_only ? ((pend_c == PEND_ADD) ? PEND_NONE : PEND_DEL) : pend_c;
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      phase_q   <= PH_A;
      pend_q    <= PEND_NONE;
      idPulse_o <= 1'b0;
      addDone_o <= 1'b0;
      delDone_o <= 1'b0;
      dropped_o <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pend_q    <= pend_d;
      idPulse_o <= id_d;
      addDone_o <= add_hit;
      delDone_o <= del_hit;
      dropped_o <= drop_d;
    end
  end
  pulse_divider #(.DIV_N(DIV_N)) u_div (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .pulse_i   (idPulse_o),
    .recClk_o  (recClk_o),
    .wrapTick_o(wrapTick_o)
  );
endmodule

// File: tb/tb_id_counter_dco.sv
// tb_id_counter_dco: directed scenarios; expected status pulses and sampled
// levels are queued by cycle number and checked by an independent monitor
module tb_id_counter_dco;
  logic clk = 1'b0, reset_i = 1'b1, carry = 1'b0, borrow = 1'b0;
  logic id_pulse, rec_clk, wrap_tick, add_done, del_done, dropped;
  int cyc = 0, n_tests = 0, n_fail = 0;
  typedef struct {int cyc; int kind;} ev_t;
  typedef struct {int cyc; int sig; logic val;} lvl_t;
  ev_t ev_q[$];
  lvl_t lvl_q[$];
  localparam int EV_WRAP = 0, EV_ADD = 1, EV_DEL = 2, EV_DROP = 3;
  localparam int S_IDP = 0, S_REC = 1, S_WRAP = 2, S_END = 3;
  string ev_name[4] = '{"wrapTick", "addDone", "delDone", "dropped"};
  string sig_name[4] = '{"idPulse", "recClk", "wrapTick", "end"};

  id_counter_dco #(.DIV_N(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .carry_i(carry), .borrow_i(borrow),
    .idPulse_o(id_pulse), .recClk_o(rec_clk), .wrapTick_o(wrap_tick),
    .addDone_o(add_done), .delDone_o(del_done), .dropped_o(dropped)
  );

  always #5 clk = ~clk;
  // cyc = number of rising edges since reset release
  always @(posedge clk or negedge reset_i) cyc <= !reset_i ? 0 : cyc + 1;

  task automatic ev_cmp(int kind);
    ev_t e;
    n_tests++;
    if (ev_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: pulse at cycle %0d, required none", ev_name[kind], cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got %s at cycle %0d, required %s at cycle %0d",
                 ev_name[kind], ev_name[kind], cyc, ev_name[e.kind], e.cyc);
      end
    end
  endtask

  task automatic lvl_cmp(lvl_t l);
    logic got;
    n_tests++;
    if (l.sig == S_END) begin
      if (ev_q.size() != 0) begin
        n_fail++;
        $display("FAIL pending_events: %0d outstanding at cycle %0d, required 0", ev_q.size(), cyc);
      end
      ev_q.delete();
    end else begin
      got = (l.sig == S_IDP) ? id_pulse : (l.sig == S_REC) ? rec_clk : wrap_tick;
      if (got !== l.val) begin
        n_fail++;
        $display("FAIL %s@%0d: got %b, required %b", sig_name[l.sig], cyc, got, l.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (wrap_tick === 1'b1) ev_cmp(EV_WRAP);
    if (add_done === 1'b1) ev_cmp(EV_ADD);
    if (del_done === 1'b1) ev_cmp(EV_DEL);
    if (dropped === 1'b1) ev_cmp(EV_DROP);
    while (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) lvl_cmp(lvl_q.pop_front());
  end

  task automatic ev(int c, int k);
    ev_q.push_back('{cyc: c, kind: k});
  endtask

  task automatic lv(int c, int s, logic v);
    lvl_q.push_back('{cyc: c, sig: s, val: v});
  endtask

  task automatic at(int n);
    wait (cyc == n);
    @(negedge clk);
  endtask

  task automatic req(int k, logic c, logic b);
    at(k - 1);
    carry = c;
    borrow = b;
    @(posedge clk);
    #1;
    carry = 1'b0;
    borrow = 1'b0;
  endtask

  task automatic hold_reset();
    reset_i = 1'b0;
    carry = 1'b0;
    borrow = 1'b0;
    lv(0, S_IDP, 1'b0);
    lv(0, S_REC, 1'b0);
    lv(0, S_WRAP, 1'b0);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    hold_reset();
  endtask

  initial begin
    // nominal stream: 32-cycle recovered clock, 50 % duty
    do_reset();
    ev(33, EV_WRAP); ev(65, EV_WRAP);
    lv(1, S_IDP, 0); lv(2, S_IDP, 1); lv(3, S_IDP, 0);
    lv(16, S_REC, 0); lv(17, S_REC, 1); lv(32, S_REC, 1); lv(33, S_REC, 0);
    lv(33, S_WRAP, 1); lv(34, S_WRAP, 0); lv(64, S_REC, 1); lv(65, S_REC, 0);
    lv(70, S_END, 0);
    at(70);
    // carry in phase B: insertion at the next edge, wrap 2 cycles early
    do_reset();
    ev(33, EV_WRAP); ev(41, EV_ADD); ev(63, EV_WRAP); ev(95, EV_WRAP);
    lv(40, S_IDP, 1); lv(41, S_IDP, 1); lv(42, S_IDP, 1); lv(43, S_IDP, 0);
    lv(100, S_END, 0);
    req(40, 1, 0);
    at(100);
    // borrow in phase A: deletion at the following B edge, wrap 2 cycles late
    do_reset();
    ev(33, EV_WRAP); ev(42, EV_DEL); ev(67, EV_WRAP); ev(99, EV_WRAP);
    lv(40, S_IDP, 1); lv(42, S_IDP, 0); lv(44, S_IDP, 1);
    lv(100, S_END, 0);
    req(41, 0, 1);
    at(100);
    // second carry while ADD pending is dropped; single insertion
    do_reset();
    ev(33, EV_WRAP); ev(40, EV_DROP); ev(41, EV_ADD); ev(63, EV_WRAP); ev(95, EV_WRAP);
    lv(41, S_IDP, 1);
    lv(100, S_END, 0);
    req(39, 1, 0);
    req(40, 1, 0);
    at(100);
    // simultaneous carry+borrow ignored; carry then borrow cancels
    do_reset();
    ev(33, EV_WRAP); ev(65, EV_WRAP);
    lv(52, S_IDP, 1); lv(53, S_IDP, 0); lv(54, S_IDP, 1);
    lv(70, S_END, 0);
    req(40, 1, 1);
    req(51, 1, 0);
    req(52, 0, 1);
    at(70);
    // mid-stream reset with ADD pending at count 9 clears everything at once
    do_reset();
    lv(18, S_IDP, 1); lv(18, S_REC, 1);
    req(19, 1, 0);
    #1;
    hold_reset();
    ev(33, EV_WRAP);
    lv(1, S_IDP, 0); lv(2, S_IDP, 1); lv(3, S_IDP, 0);
    lv(40, S_END, 0);
    at(40);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
